debounce_multi: RTL



---
 rtl/debounce_defs.sv | 31 +++
 rtl/debounce_chan.sv | 115 +++++++++++
 rtl/debounce_multi.sv | 42 ++++
 3 files changed

// File: rtl/debounce_defs.sv
// Shared defaults and parameter legality checks for the multi-channel debouncer.
// Board tops override the defaults here so every channel picks them up in one place.
package debounce_defs;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_STABLE_CNT  = 255;
  localparam int DEF_SYNC_STAGES = 2;
  localparam bit DEF_INIT_VAL    = 1'b0;
  localparam int DEF_HOLD_W      = 24;
  localparam int DEF_HOLD_CNT    = 0;

  // True when val is representable in an unsigned field of the given width.
  function automatic bit fits_width(input longint val, input int width);
    if (width >= 63) return 1'b1;
    return (val >= 0) && (val < (longint'(1) << width));
  endfunction

  function automatic bit stable_cnt_ok(input int stable_cnt, input int cnt_w);
    return (stable_cnt >= 1) && fits_width(longint'(stable_cnt), cnt_w);
  endfunction

  function automatic bit hold_cnt_ok(input int hold_cnt, input int hold_w);
    return (hold_cnt >= 0) && fits_width(longint'(hold_cnt), hold_w);
  endfunction

  function automatic bit sync_stages_ok(input int sync_stages);
    return sync_stages >= 2;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: input synchroniser, stability filter with registered
// rise/fall pulses, and a saturating long-press (hold) counter.
module debounce_chan
  import debounce_defs::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit INIT_VAL    = DEF_INIT_VAL,
  parameter int HOLD_W      = DEF_HOLD_W,
  parameter int HOLD_CNT    = DEF_HOLD_CNT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic hold_o
);

  if (!stable_cnt_ok(STABLE_CNT, CNT_W)) begin : g_err_stable
    $error("debounce_chan: STABLE_CNT must be in 1..2^CNT_W-1");
  end
  if (!hold_cnt_ok(HOLD_CNT, HOLD_W)) begin : g_err_hold
    $error("debounce_chan: HOLD_CNT must be below 2^HOLD_W");
  end
  if (!sync_stages_ok(SYNC_STAGES)) begin : g_err_sync
    $error("debounce_chan: SYNC_STAGES must be at least 2");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic [SYNC_STAGES-1:0] sync_q;
  logic in_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{INIT_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  assign in_s = sync_q[SYNC_STAGES-1];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any sample matching OUT restarts the count, so only an unbroken run flips OUT.
  always_comb begin
    cnt_d  = '0;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (in_s != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d  = in_s;
        rise_d = in_s;
        fall_d = ~in_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      out_q  <= INIT_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

  if (HOLD_CNT == 0) begin : g_no_hold
    assign hold_o = 1'b0;
  end else begin : g_hold
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT);

    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              hold_q, hold_d;

    // Counter saturates at HOLD_LAST; HOLD is the registered compare, one cycle behind.
    always_comb begin
      hcnt_d = '0;
      hold_d = 1'b0;
      if (out_q) begin
        hcnt_d = (hcnt_q == HOLD_LAST) ? hcnt_q : hcnt_q + HOLD_W'(1);
        hold_d = (hcnt_q == HOLD_LAST);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hcnt_q <= '0;
        hold_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_d;
        hold_q <= hold_d;
      end
    end

    assign hold_o = hold_q;
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: N_CH fully independent debounce_chan instances
// sharing only the clock and synchronous reset.
module debounce_multi
  import debounce_defs::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit INIT_VAL    = DEF_INIT_VAL,
  parameter int HOLD_W      = DEF_HOLD_W,
  parameter int HOLD_CNT    = DEF_HOLD_CNT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] IN,
  output logic [N_CH-1:0] OUT,
  output logic [N_CH-1:0] RISE,
  output logic [N_CH-1:0] FALL,
  output logic [N_CH-1:0] HOLD
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_chan #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT),
      .SYNC_STAGES(SYNC_STAGES),
      .INIT_VAL   (INIT_VAL),
      .HOLD_W     (HOLD_W),
      .HOLD_CNT   (HOLD_CNT)
    ) u_chan (
      .clk_i (CLK),
      .rst_i (RST),
      .in_i  (IN[i]),
      .out_o (OUT[i]),
      .rise_o(RISE[i]),
      .fall_o(FALL[i]),
      .hold_o(HOLD[i])
    );
  end

endmodule
